// File: rtl/demosaic_wsum_clamp.sv
// demosaic_wsum_clamp
//   Accumulates TAPS signed products per output pixel, then rounds half-up by
//   SHIFT bits, clamps the result to [0, 2^OUT_W-1] and holds it in a single
//   registered output slot on a valid/ready stream.
//
// Ports
//   ap_clk   : clock, rising edge
//   ap_rst   : synchronous active-high reset
//   s_prod   : signed product input (IN_W)
//   s_valid  : s_prod / s_last valid
//   s_ready  : input accepted this cycle (~m_valid | m_ready)
//   s_last   : end-of-line marker, sampled on the final tap only
//   m_pix    : rounded, clamped pixel (OUT_W)
//   m_valid  : m_pix / m_last valid
//   m_ready  : downstream accepts output
//   m_last   : end-of-line flag of this pixel
//   tap_idx  : index of the next tap expected
module demosaic_wsum_clamp #(
  parameter int IN_W  = 28,
  parameter int TAPS  = 4,
  parameter int SHIFT = 16,
  parameter int OUT_W = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [IN_W-1:0]          s_prod,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_last,
  output logic [OUT_W-1:0]         m_pix,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [$clog2(TAPS)-1:0]  tap_idx
);

  localparam int CNT_W = $clog2(TAPS);
  localparam int ACC_W = IN_W + CNT_W;
  localparam logic [ACC_W:0]   HALF    = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [CNT_W-1:0] LAST_T  = CNT_W'(TAPS - 1);
  localparam logic [OUT_W-1:0] PIX_MAX = '1;

  logic [CNT_W-1:0]        tap_cnt;
  logic signed [ACC_W-1:0] acc, prod_x, sum;
  logic signed [ACC_W:0]   rnd, r;
  logic [OUT_W-1:0]        pix_c;
  logic                    in_xfer, out_xfer, last_tap;

  assign s_ready  = ~m_valid | m_ready;
  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;
  assign last_tap = (tap_cnt == LAST_T);
  assign tap_idx  = tap_cnt;

  assign prod_x = {{CNT_W{s_prod[IN_W-1]}}, s_prod};
  assign sum    = acc + prod_x;
  // one guard bit so adding the rounding constant can never overflow
  assign rnd    = {sum[ACC_W-1], sum} + HALF;
  assign r      = rnd >>> SHIFT;

  always_comb begin
    pix_c = r[OUT_W-1:0];
    if (r[ACC_W])                 pix_c = '0;
    else if (|r[ACC_W-1:OUT_W])   pix_c = PIX_MAX;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      tap_cnt <= '0;
      acc     <= '0;
      m_valid <= 1'b0;
      m_pix   <= '0;
      m_last  <= 1'b0;
    end else begin
      if (out_xfer) m_valid <= 1'b0;
      if (in_xfer) begin
        if (last_tap) begin
          // reload wins over the drain, so m_valid stays high
          m_pix   <= pix_c;
          m_last  <= s_last;
          m_valid <= 1'b1;
          tap_cnt <= '0;
        end else begin
          acc     <= (tap_cnt == '0) ? prod_x : sum;
          tap_cnt <= tap_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
